ft600_bus_sched: RTL and testbench

FT600_BUS_SCHED -- requirements
Module: ft600_bus_sched

---
 rtl/ft600_bus_sched.sv | 82 ++++++++
 tb/tb_ft600_bus_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft600_bus_sched.sv
// ft600_bus_sched: FT600 245-mode bus scheduler arbitrating read/write bursts on a shared AD bus
module ft600_bus_sched #(
  parameter int BURST_MAX = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        usb_rxf,
  input  logic        usb_txe,
  output logic        usb_rd_n,
  output logic        usb_wr_n,
  output logic        usb_oe_n,
  input  logic [15:0] usb_ad_i,
  output logic [15:0] usb_ad_o,
  output logic        usb_ad_t,
  input  logic        txenq__ENA,
  input  logic [15:0] txenq_v,
  output logic        txenq__RDY,
  output logic        rxenq__ENA,
  output logic [15:0] rxenq_v,
  input  logic        rxenq__RDY,
  output logic [31:0] rdWords,
  output logic [31:0] wrWords,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, RD_OE, RD_BURST, WR_BURST, TURN} state_t;
  state_t state, nxt;
  logic last_wr;
  logic [10:0] cnt;
  logic cnt_ok, rd_req, wr_req, tx_take;
  assign cnt_ok = cnt < 11'(BURST_MAX);
  assign rd_req = !usb_rxf && rxenq__RDY;
  assign wr_req = !usb_txe && txenq__ENA;
  assign tx_take = txenq__ENA && txenq__RDY;
  assign rxenq_v = usb_ad_i;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    usb_rd_n = 1'b1;
    usb_wr_n = 1'b1;
    usb_oe_n = 1'b1;
    usb_ad_t = 1'b1;
    usb_ad_o = '0;
    txenq__RDY = 1'b0;
    rxenq__ENA = 1'b0;
    case (state)
      IDLE: nxt = (rd_req && (!wr_req || last_wr)) ? RD_OE : wr_req ? WR_BURST : IDLE;
      RD_OE: begin
        usb_oe_n = 1'b0;
        nxt = RD_BURST;
      end
      RD_BURST: begin
        usb_oe_n = 1'b0;
        usb_rd_n = !(rxenq__RDY && !usb_rxf && cnt_ok);
        rxenq__ENA = !usb_rd_n && !usb_rxf;
        nxt = usb_rd_n ? TURN : RD_BURST;
      end
      WR_BURST: begin
        usb_ad_t = 1'b0;
        txenq__RDY = !usb_txe && cnt_ok;
        usb_wr_n = !(txenq__ENA && txenq__RDY);
        usb_ad_o = txenq_v;
        nxt = usb_wr_n ? TURN : WR_BURST;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      last_wr <= 1'b1;
      cnt <= '0;
      rdWords <= '0;
      wrWords <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt != IDLE) last_wr <= nxt == WR_BURST;
      cnt <= state == IDLE ? '0 : cnt + 11'(rxenq__ENA || tx_take);
      rdWords <= rdWords + 32'(rxenq__ENA);
      wrWords <= wrWords + 32'(tx_take);
    end
  end
endmodule

// File: tb/tb_ft600_bus_sched.sv
// tb_ft600_bus_sched: directed scenario bench for ft600_bus_sched (default and BURST_MAX=4 instances)
module tb_ft600_bus_sched;
  logic CLK = 0, nRST = 0;
  logic usb_rxf = 1, usb_txe = 1, tx_ena = 0, rx_rdy = 0;
  logic [15:0] ad_i = 0, tx_v = 0;
  logic rd_n, wr_n, oe_n, ad_t, tx_rdy, rx_ena, busy;
  logic [15:0] ad_o, rx_v;
  logic [31:0] rd_words, wr_words;
  logic b_rd_n, b_wr_n, b_oe_n, b_ad_t, b_tx_rdy, b_rx_ena, b_busy;
  logic [15:0] b_ad_o, b_rx_v;
  logic [31:0] b_rd_words, b_wr_words;
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  ft600_bus_sched dut (
    .CLK(CLK), .nRST(nRST), .usb_rxf(usb_rxf), .usb_txe(usb_txe),
    .usb_rd_n(rd_n), .usb_wr_n(wr_n), .usb_oe_n(oe_n),
    .usb_ad_i(ad_i), .usb_ad_o(ad_o), .usb_ad_t(ad_t),
    .txenq__ENA(tx_ena), .txenq_v(tx_v), .txenq__RDY(tx_rdy),
    .rxenq__ENA(rx_ena), .rxenq_v(rx_v), .rxenq__RDY(rx_rdy),
    .rdWords(rd_words), .wrWords(wr_words), .busy(busy)
  );

  ft600_bus_sched #(.BURST_MAX(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .usb_rxf(usb_rxf), .usb_txe(usb_txe),
    .usb_rd_n(b_rd_n), .usb_wr_n(b_wr_n), .usb_oe_n(b_oe_n),
    .usb_ad_i(ad_i), .usb_ad_o(b_ad_o), .usb_ad_t(b_ad_t),
    .txenq__ENA(tx_ena), .txenq_v(tx_v), .txenq__RDY(b_tx_rdy),
    .rxenq__ENA(b_rx_ena), .rxenq_v(b_rx_v), .rxenq__RDY(rx_rdy),
    .rdWords(b_rd_words), .wrWords(b_wr_words), .busy(b_busy)
  );

  task automatic do_reset;
    @(negedge CLK);
    nRST = 0; usb_rxf = 1; usb_txe = 1; tx_ena = 0; rx_rdy = 0; ad_i = 0; tx_v = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    nRST = 0; usb_rxf = 0; rx_rdy = 1; usb_txe = 0; tx_ena = 1; tx_v = 16'hBEEF;
    @(negedge CLK);
    #1;
    total++;
    if ({rd_n, wr_n, oe_n, ad_t, tx_rdy, rx_ena, busy} !== 7'b1111000)
      begin bad++; $display("FAIL reset_strobes got=%b want=1111000", {rd_n, wr_n, oe_n, ad_t, tx_rdy, rx_ena, busy}); end
    total++;
    if (ad_o !== 16'h0) begin bad++; $display("FAIL reset_ad_o got=%h want=0000", ad_o); end
    total++;
    if (rd_words !== 0 || wr_words !== 0)
      begin bad++; $display("FAIL reset_totals got=%0d/%0d want=0/0", rd_words, wr_words); end
    total++;
    if ({b_rd_n, b_wr_n, b_oe_n, b_ad_t, b_tx_rdy, b_rx_ena, b_busy} !== 7'b1111000)
      begin bad++; $display("FAIL reset_strobes4 got=%b want=1111000", {b_rd_n, b_wr_n, b_oe_n, b_ad_t, b_tx_rdy, b_rx_ena, b_busy}); end
    do_reset;
  endtask

  task automatic test_read;
    do_reset;
    @(negedge CLK); usb_rxf = 0; rx_rdy = 1; #1;
    total++;
    if (busy !== 0 || oe_n !== 1) begin bad++; $display("FAIL read_idle got=%b%b want=01", busy, oe_n); end
    @(negedge CLK); #1;
    total++;
    if ({oe_n, rd_n, ad_t, rx_ena, busy} !== 5'b01101)
      begin bad++; $display("FAIL read_oe got=%b want=01101", {oe_n, rd_n, ad_t, rx_ena, busy}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); ad_i = 16'(16'hA5A0 + i); #1;
      total++;
      if ({rd_n, oe_n, ad_t, rx_ena} !== 4'b0011 || rx_v !== ad_i)
        begin bad++; $display("FAIL read_word%0d got=%b/%h want=0011/%h", i, {rd_n, oe_n, ad_t, rx_ena}, rx_v, ad_i); end
    end
    @(negedge CLK); usb_rxf = 1; #1;
    total++;
    if ({rd_n, rx_ena, oe_n, busy} !== 4'b1001)
      begin bad++; $display("FAIL read_end got=%b want=1001", {rd_n, rx_ena, oe_n, busy}); end
    @(negedge CLK); #1;
    total++;
    if ({busy, oe_n, rd_n, wr_n, ad_t} !== 5'b11111)
      begin bad++; $display("FAIL read_turn got=%b want=11111", {busy, oe_n, rd_n, wr_n, ad_t}); end
    @(negedge CLK); #1;
    total++;
    if (busy !== 0 || rd_words !== 5) begin bad++; $display("FAIL read_total got=%b/%0d want=0/5", busy, rd_words); end
  endtask

  task automatic test_write;
    int k, cur, nb, drive_bad;
    int lens[4];
    bit was_end;
    k = 0; cur = 0; nb = 0; drive_bad = 0; was_end = 0;
    do_reset;
    repeat (40) begin
      @(negedge CLK); usb_txe = 0; tx_ena = k < 10; tx_v = 16'(16'h0100 + k); #1;
      if (b_ad_t === 0 && (b_oe_n !== 1 || b_busy !== 1)) drive_bad++;
      if (was_end) begin
        total++;
        if ({b_busy, b_ad_t, b_wr_n} !== 3'b111)
          begin bad++; $display("FAIL write_turn got=%b want=111", {b_busy, b_ad_t, b_wr_n}); end
      end
      was_end = 0;
      if (b_tx_rdy && tx_ena) begin
        total++;
        if (b_wr_n !== 0 || b_ad_o !== tx_v || b_ad_t !== 0)
          begin bad++; $display("FAIL write_word%0d got=%b%b/%h want=00/%h", k, b_wr_n, b_ad_t, b_ad_o, tx_v); end
        k++; cur++;
      end else if (b_ad_t === 0) begin
        if (nb < 4) lens[nb] = cur;
        nb++; cur = 0; was_end = 1;
      end
    end
    total++;
    if (nb !== 3) begin bad++; $display("FAIL write_bursts got=%0d want=3", nb); end
    else begin
      total++;
      if (lens[0] !== 4 || lens[1] !== 4 || lens[2] !== 2)
        begin bad++; $display("FAIL write_lens got=%0d,%0d,%0d want=4,4,2", lens[0], lens[1], lens[2]); end
    end
    total++;
    if (b_wr_words !== 10 || k !== 10) begin bad++; $display("FAIL write_total got=%0d/%0d want=10/10", b_wr_words, k); end
    total++;
    if (drive_bad !== 0) begin bad++; $display("FAIL write_drive got=%0d want=0", drive_bad); end
    tx_ena = 0; usb_txe = 1;
  endtask

  task automatic test_contention;
    int grants, alt_bad, drive_bad, len_bad, cur;
    bit prev_busy, last_rd, first_rd, is_rd;
    grants = 0; alt_bad = 0; drive_bad = 0; len_bad = 0; cur = 0;
    prev_busy = 0; last_rd = 0; first_rd = 0;
    do_reset;
    repeat (450) begin
      @(negedge CLK); usb_rxf = 0; rx_rdy = 1; usb_txe = 0; tx_ena = 1; ad_i = ad_i + 1; tx_v = tx_v + 3; #1;
      if (ad_t === 0 && oe_n === 0) drive_bad++;
      if (!prev_busy && busy) begin
        is_rd = oe_n === 0;
        if (grants == 0) first_rd = is_rd;
        else begin
          if (is_rd == last_rd) alt_bad++;
          if (cur != 64) len_bad++;
        end
        last_rd = is_rd; grants++; cur = 0;
      end
      if (rx_ena === 1 || (tx_rdy === 1 && tx_ena)) cur++;
      prev_busy = busy;
    end
    total++;
    if (first_rd !== 1) begin bad++; $display("FAIL cont_first got=%b want=1", first_rd); end
    total++;
    if (grants < 5) begin bad++; $display("FAIL cont_grants got=%0d want>=5", grants); end
    total++;
    if (alt_bad !== 0) begin bad++; $display("FAIL cont_alternate got=%0d want=0", alt_bad); end
    total++;
    if (drive_bad !== 0) begin bad++; $display("FAIL cont_drive got=%0d want=0", drive_bad); end
    total++;
    if (len_bad !== 0) begin bad++; $display("FAIL cont_burstlen got=%0d want=0", len_bad); end
    tx_ena = 0; usb_txe = 1; usb_rxf = 1;
  endtask

  task automatic test_backpressure;
    do_reset;
    @(negedge CLK); usb_rxf = 0; rx_rdy = 1; #1;
    @(negedge CLK); #1;
    total++;
    if ({oe_n, rd_n} !== 2'b01) begin bad++; $display("FAIL bp_oe got=%b want=01", {oe_n, rd_n}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); ad_i = 16'(16'h3C00 + i); #1;
      total++;
      if (rx_ena !== 1 || rd_n !== 0 || rx_v !== ad_i)
        begin bad++; $display("FAIL bp_word%0d got=%b%b/%h want=10/%h", i, rx_ena, rd_n, rx_v, ad_i); end
    end
    @(negedge CLK); rx_rdy = 0; ad_i = 16'h3C03; #1;
    total++;
    if ({rd_n, rx_ena, busy} !== 3'b101) begin bad++; $display("FAIL bp_stall got=%b want=101", {rd_n, rx_ena, busy}); end
    @(negedge CLK); usb_rxf = 1; #1;
    total++;
    if ({busy, oe_n, rx_ena} !== 3'b110) begin bad++; $display("FAIL bp_turn got=%b want=110", {busy, oe_n, rx_ena}); end
    @(negedge CLK); #1;
    total++;
    if (busy !== 0 || rd_words !== 3) begin bad++; $display("FAIL bp_total got=%b/%0d want=0/3", busy, rd_words); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    @(negedge CLK); usb_txe = 0; tx_ena = 1; tx_v = 16'h1111; #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); tx_v = 16'(16'h2220 + i); #1;
      total++;
      if (wr_n !== 0 || ad_t !== 0 || ad_o !== tx_v)
        begin bad++; $display("FAIL mid_word%0d got=%b%b/%h want=00/%h", i, wr_n, ad_t, ad_o, tx_v); end
    end
    @(negedge CLK); nRST = 0; tx_v = 16'h2222; #1;
    @(negedge CLK); #1;
    total++;
    if ({rd_n, wr_n, oe_n, ad_t, busy, tx_rdy} !== 6'b111100 || ad_o !== 16'h0)
      begin bad++; $display("FAIL mid_outputs got=%b/%h want=111100/0000", {rd_n, wr_n, oe_n, ad_t, busy, tx_rdy}, ad_o); end
    total++;
    if (wr_words !== 0) begin bad++; $display("FAIL mid_total got=%0d want=0", wr_words); end
    nRST = 1; tx_ena = 0; usb_txe = 1;
  endtask

  task automatic test_wrap;
    int n;
    n = 0;
    do_reset;
    @(negedge CLK); force dut.wrWords = 32'hFFFF_FFFE;
    @(negedge CLK); release dut.wrWords; #1;
    total++;
    if (wr_words !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_preset got=%h want=fffffffe", wr_words); end
    repeat (10) begin
      @(negedge CLK); usb_txe = 0; tx_ena = n < 3; tx_v = 16'(16'h7700 + n); #1;
      if (tx_rdy && tx_ena) begin
        n++;
        if (n == 2) begin
          total++;
          if (wr_words !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_mid got=%h want=ffffffff", wr_words); end
        end
      end
    end
    total++;
    if (wr_words !== 32'h1 || n !== 3) begin bad++; $display("FAIL wrap_final got=%h/%0d want=00000001/3", wr_words, n); end
    tx_ena = 0; usb_txe = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_read;
    test_write;
    test_contention;
    test_backpressure;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
